// File: rtl/result_pkg.sv
// Shared constants and helpers for the result collector and its storage banks.
package result_pkg;
  localparam int DATA_W_DEF = 21;
  localparam int NUM_CH_DEF = 32;
  localparam int GROUP_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] res_word_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/result_bank.sv
// One frame of channel storage: indexed single-word write, whole-frame flat read.
module result_bank
  import result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [idx_w(NUM_CH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [NUM_CH*DATA_W-1:0]   rd_flat
);

  logic [DATA_W-1:0] mem [NUM_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) mem[k] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rd
    assign rd_flat[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: rtl/result_collector.sv
// Ping-pong collector: serial words fill one bank while the other is presented
// downstream as a parallel frame; partial groups roll back on input breaks.
module result_collector
  import result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int GROUP  = GROUP_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      srdyi,
  input  logic [DATA_W-1:0]         fp_res,
  output logic                      drdyo,
  output logic                      srdyo,
  input  logic                      drdyi,
  output logic [NUM_CH*DATA_W-1:0]  res_flat,
  output logic                      ovf,
  input  logic                      clr_ovf
);

  localparam int IW = idx_w(NUM_CH);
  localparam int GW = idx_w(GROUP);

  logic          fill_sel;
  logic          full;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] commit_idx;
  logic [GW-1:0] grp_cnt;
  logic          accept;
  logic          last_acc;
  logic          consume;
  logic          swap;
  logic [NUM_CH*DATA_W-1:0] flat_a;
  logic [NUM_CH*DATA_W-1:0] flat_b;

  assign drdyo    = ~full;
  assign accept   = srdyi & drdyo;
  assign last_acc = accept & (wr_idx == IW'(NUM_CH - 1));
  assign consume  = srdyo & drdyi;
  // A complete fill bank moves to the output as soon as the output is free or leaving.
  assign swap     = (full | last_acc) & (~srdyo | consume);

  result_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_bank_a (
    .clk     (clk),
    .reset   (reset),
    .we      (accept & ~fill_sel),
    .idx     (wr_idx),
    .wdata   (fp_res),
    .rd_flat (flat_a)
  );

  result_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_bank_b (
    .clk     (clk),
    .reset   (reset),
    .we      (accept & fill_sel),
    .idx     (wr_idx),
    .wdata   (fp_res),
    .rd_flat (flat_b)
  );

  assign res_flat = fill_sel ? flat_a : flat_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_sel   <= 1'b0;
      full       <= 1'b0;
      srdyo      <= 1'b0;
      wr_idx     <= '0;
      commit_idx <= '0;
      grp_cnt    <= '0;
    end else if (swap) begin
      fill_sel   <= ~fill_sel;
      full       <= 1'b0;
      srdyo      <= 1'b1;
      wr_idx     <= '0;
      commit_idx <= '0;
      grp_cnt    <= '0;
    end else begin
      if (consume)  srdyo <= 1'b0;
      if (last_acc) full  <= 1'b1;
      if (accept) begin
        wr_idx <= wr_idx + IW'(1);
        if (grp_cnt == GW'(GROUP - 1)) begin
          grp_cnt    <= '0;
          commit_idx <= wr_idx + IW'(1);
        end else begin
          grp_cnt <= grp_cnt + GW'(1);
        end
      end else if (!srdyi && (wr_idx != commit_idx)) begin
        // Stream broke mid-group: stale slots get overwritten on the retry.
        wr_idx  <= commit_idx;
        grp_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              ovf <= 1'b0;
    else if (srdyi & ~drdyo) ovf <= 1'b1;
    else if (clr_ovf)        ovf <= 1'b0;
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a frame-queue reference model.
module tb_result_collector;
  localparam int DW  = 21;
  localparam int NCH = 32;
  localparam int GRP = 8;
  localparam int FW  = NCH * DW;
  localparam int DW2 = 8;
  localparam int NC2 = 16;

  logic clk = 1'b0;
  logic reset;
  logic srdyi, drdyi, clr_ovf;
  logic [DW-1:0] fp_res;
  logic drdyo, srdyo, ovf;
  logic [FW-1:0] res_flat;

  logic s2_srdyi;
  logic [DW2-1:0] s2_fp;
  logic s2_drdyo, s2_srdyo, s2_ovf;
  logic [NC2*DW2-1:0] s2_flat;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: completed frames waiting or on display, plus the partial frame.
  logic [FW-1:0] mq [$];
  logic [FW-1:0] m_part;
  int m_n, m_commit;
  bit m_ovf;

  always #5 clk = ~clk;

  result_collector #(.DATA_W(DW), .NUM_CH(NCH), .GROUP(GRP)) dut (
    .clk(clk), .reset(reset), .srdyi(srdyi), .fp_res(fp_res), .drdyo(drdyo),
    .srdyo(srdyo), .drdyi(drdyi), .res_flat(res_flat), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  result_collector #(.DATA_W(DW2), .NUM_CH(NC2), .GROUP(1)) dut2 (
    .clk(clk), .reset(reset), .srdyi(s2_srdyi), .fp_res(s2_fp), .drdyo(s2_drdyo),
    .srdyo(s2_srdyo), .drdyi(1'b1), .res_flat(s2_flat), .ovf(s2_ovf), .clr_ovf(1'b0)
  );

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] ch(input int k);
    return res_flat[k*DW +: DW];
  endfunction

  function automatic logic [DW2-1:0] ch2(input int k);
    return s2_flat[k*DW2 +: DW2];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_part   = '0;
    m_n      = 0;
    m_commit = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy;
    bit acc;
    rdy = (mq.size() < 2);
    acc = srdyi && rdy;
    if (srdyi && !rdy) m_ovf = 1'b1;
    else if (clr_ovf)  m_ovf = 1'b0;
    if (mq.size() > 0 && drdyi) void'(mq.pop_front());
    if (acc) begin
      m_part[m_n*DW +: DW] = fp_res;
      m_n++;
      if (m_n % GRP == 0) m_commit = m_n;
      if (m_n == NCH) begin
        mq.push_back(m_part);
        m_n = 0;
        m_commit = 0;
      end
    end else if (!srdyi) begin
      m_n = m_commit;
    end
  endtask

  task automatic compare();
    chk("srdyo", FW'(srdyo), FW'(mq.size() > 0));
    chk("drdyo", FW'(drdyo), FW'(mq.size() < 2));
    chk("ovf", FW'(ovf), FW'(m_ovf));
    if (mq.size() > 0) chk("res_flat", res_flat, mq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic send(input int w);
    srdyi = 1'b1;
    fp_res = DW'(w);
    step();
  endtask

  task automatic idle(input int n);
    srdyi = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send2(input int w);
    s2_srdyi = 1'b1;
    s2_fp = DW2'(w);
    step();
    s2_srdyi = 1'b0;
  endtask

  initial begin
    int hi;
    reset = 1'b0; srdyi = 1'b0; drdyi = 1'b1; clr_ovf = 1'b0; fp_res = '0;
    s2_srdyi = 1'b0; s2_fp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_srdyo", FW'(srdyo), FW'(0));
    chk("rst_drdyo", FW'(drdyo), FW'(1));
    chk("rst_ovf", FW'(ovf), FW'(0));
    chk("rst_flat", res_flat, FW'(0));
    reset = 1'b1;
    idle(2);

    // Contiguous frame 1..32 with downstream always ready.
    hi = 0;
    for (int w = 1; w <= 32; w++) begin
      send(w);
      if (srdyo) hi++;
    end
    for (int k = 0; k < NCH; k++) chk("t1_ch", FW'(ch(k)), FW'(k + 1));
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (srdyo) hi++;
    end
    chk("t1_srdyo_cycles", FW'(hi), FW'(1));

    // Break after 12 words: second half-group is retried from slot 8.
    for (int w = 1; w <= 12; w++) send(w);
    idle(1);
    for (int w = 100; w <= 122; w++) send(w);
    chk("t2_not_yet", FW'(srdyo), FW'(0));
    send(123);
    chk("t2_done", FW'(srdyo), FW'(1));
    chk("t2_ch0", FW'(ch(0)), FW'(1));
    chk("t2_ch7", FW'(ch(7)), FW'(8));
    chk("t2_ch8", FW'(ch(8)), FW'(100));
    chk("t2_ch31", FW'(ch(31)), FW'(123));
    for (int w = 124; w <= 127; w++) send(w);
    idle(3);

    // Downstream stalled: second frame backs up, then overflow and clear.
    drdyi = 1'b0;
    for (int w = 201; w <= 264; w++) send(w);
    chk("t3_drdyo_low", FW'(drdyo), FW'(0));
    chk("t3_ch0_held", FW'(ch(0)), FW'(201));
    send(999);
    chk("t3_ovf_set", FW'(ovf), FW'(1));
    clr_ovf = 1'b1;
    send(998);
    chk("t3_ovf_set_wins", FW'(ovf), FW'(1));
    idle(1);
    chk("t3_ovf_clr", FW'(ovf), FW'(0));
    clr_ovf = 1'b0;
    drdyi = 1'b1;
    idle(1);
    chk("t3_srdyo_kept", FW'(srdyo), FW'(1));
    chk("t3_ch0_f2", FW'(ch(0)), FW'(233));
    chk("t3_drdyo_back", FW'(drdyo), FW'(1));
    idle(2);

    // Consume lands on the same edge as the next frame's last word.
    drdyi = 1'b0;
    for (int w = 301; w <= 332; w++) send(w);
    for (int w = 401; w <= 431; w++) send(w);
    chk("t4_ch0_a", FW'(ch(0)), FW'(301));
    drdyi = 1'b1;
    send(432);
    chk("t4_srdyo", FW'(srdyo), FW'(1));
    chk("t4_ch0_b", FW'(ch(0)), FW'(401));
    chk("t4_ch31_b", FW'(ch(31)), FW'(432));
    idle(2);

    // Asynchronous reset in the middle of a frame.
    drdyi = 1'b0;
    for (int w = 501; w <= 532; w++) send(w);
    for (int w = 1; w <= 20; w++) send(w);
    srdyi = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t5_srdyo", FW'(srdyo), FW'(0));
    chk("t5_drdyo", FW'(drdyo), FW'(1));
    chk("t5_ovf", FW'(ovf), FW'(0));
    chk("t5_flat", res_flat, FW'(0));
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    drdyi = 1'b1;
    for (int w = 601; w <= 632; w++) send(w);
    chk("t5_srdyo_new", FW'(srdyo), FW'(1));
    chk("t5_ch0", FW'(ch(0)), FW'(601));
    chk("t5_ch19", FW'(ch(19)), FW'(620));
    chk("t5_ch31", FW'(ch(31)), FW'(632));
    idle(2);

    // Small configuration with per-word commit: a gap loses nothing.
    for (int w = 1; w <= 5; w++) send2(w);
    idle(1);
    for (int w = 6; w <= 15; w++) send2(w);
    chk("t6_not_yet", FW'(s2_srdyo), FW'(0));
    send2(16);
    chk("t6_srdyo", FW'(s2_srdyo), FW'(1));
    for (int k = 0; k < NC2; k++) chk("t6_ch", FW'(ch2(k)), FW'(k + 1));
    chk("t6_ovf", FW'(s2_ovf), FW'(0));
    chk("t6_drdyo", FW'(s2_drdyo), FW'(1));
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
